// File: rtl/toggle_pulse_gen.sv
// Push-button debouncer that emits one toggle request per accepted press
// and keeps a running count of accepted presses.
//
// state | meaning
// IDLE  | button released and stable
// PCHK  | press seen, counting consecutive high samples
// HELD  | press accepted, waiting for a release
// RCHK  | release seen, counting consecutive low samples
module toggle_pulse_gen #(
    parameter int DEB_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pb_in,
    output logic       t_pulse,
    output logic       pb_level,
    output logic [7:0] press_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PCHK = 2'd1,
        HELD = 2'd2,
        RCHK = 2'd3
    } state_t;

    localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] press_cnt_q, press_cnt_d;
    logic       sync1_q, sync1_d;
    logic       sync2_q, sync2_d;
    logic       t_pulse_q, t_pulse_d;
    logic       pb_level_q, pb_level_d;
    logic       s;

    assign s = sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            t_pulse_q   <= 1'b0;
            pb_level_q  <= 1'b0;
            press_cnt_q <= 8'd0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            t_pulse_q   <= t_pulse_d;
            pb_level_q  <= pb_level_d;
            press_cnt_q <= press_cnt_d;
        end
    end

    always_comb begin
        sync1_d     = pb_in;
        sync2_d     = sync1_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        t_pulse_d   = 1'b0;
        press_cnt_d = press_cnt_q;

        case (state_q)
            IDLE: begin
                if (s) begin
                    state_d = PCHK;
                    cnt_d   = 8'd1;
                end else begin
                    cnt_d = 8'd0;
                end
            end
            PCHK: begin
                if (!s) begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end else if (cnt_q == DEB_LAST) begin
                    // Only the press acceptance pulses; RCHK->HELD is silent.
                    state_d     = HELD;
                    cnt_d       = 8'd0;
                    t_pulse_d   = 1'b1;
                    press_cnt_d = press_cnt_q + 8'd1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            HELD: begin
                if (!s) begin
                    state_d = RCHK;
                    cnt_d   = 8'd1;
                end
            end
            RCHK: begin
                if (s) begin
                    state_d = HELD;
                    cnt_d   = 8'd0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
        endcase

        pb_level_d = (state_d == HELD) || (state_d == RCHK);
    end

    assign t_pulse   = t_pulse_q;
    assign pb_level  = pb_level_q;
    assign press_cnt = press_cnt_q;

endmodule

// File: tb/tb_toggle_pulse_gen.sv
// Scoreboard bench for toggle_pulse_gen: stimulus queues expected pulses
// (cycle and count), a negedge monitor pops one per observed t_pulse.
module tb_toggle_pulse_gen;

    logic       clk;
    logic       rst_n;
    logic       pb_in;
    logic       t_pulse;
    logic       pb_level;
    logic [7:0] press_cnt;

    typedef struct {
        int         cyc;
        logic [7:0] cnt;
    } exp_t;

    exp_t       exp_q[$];
    int         cyc;
    int         checks;
    int         errors;
    logic [7:0] exp_cnt;
    logic       tff;

    toggle_pulse_gen #(.DEB_CYCLES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pb_in     (pb_in),
        .t_pulse   (t_pulse),
        .pb_level  (pb_level),
        .press_cnt (press_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Downstream toggle flip-flop driven by t_pulse.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tff <= 1'b0;
        else if (t_pulse) tff <= ~tff;
    end

    always @(negedge clk) begin
        if (t_pulse === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse cyc=%0d press_cnt=%0d required=no pulse", cyc, press_cnt);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.cyc != cyc || press_cnt !== e.cnt || pb_level !== 1'b1) begin
                    errors++;
                    $display("FAIL pulse got cyc=%0d cnt=%0d lvl=%0b required cyc=%0d cnt=%0d lvl=1",
                             cyc, press_cnt, pb_level, e.cyc, e.cnt);
                end
            end
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0d required=%0d (cyc=%0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int k);
        repeat (k) @(negedge clk);
    endtask

    // Raise pb_in at a negedge; the next rising edge is the first sampling edge n.
    task automatic press_expect();
        exp_t e;
        pb_in   = 1'b1;
        exp_cnt = exp_cnt + 8'd1;
        e.cyc   = cyc + 1 + 5;
        e.cnt   = exp_cnt;
        exp_q.push_back(e);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        exp_cnt = 8'd0;
        pb_in   = 1'b0;
        rst_n   = 1'b0;
        tick(3);
        check("rst_t_pulse", {7'd0, t_pulse}, 8'd0);
        check("rst_pb_level", {7'd0, pb_level}, 8'd0);
        check("rst_press_cnt", press_cnt, 8'd0);
        rst_n = 1'b1;
        tick(5);

        // Clean press and long hold: one pulse at n+5.
        press_expect();
        tick(5);
        check("lvl_before_accept", {7'd0, pb_level}, 8'd0);
        tick(1);
        check("lvl_after_accept", {7'd0, pb_level}, 8'd1);
        tick(20);
        pb_in = 1'b0;
        tick(15);
        check("lvl_after_release", {7'd0, pb_level}, 8'd0);
        check("cnt_after_press1", press_cnt, 8'd1);

        // Bounce 1,0,1,0 then stable high: pulse 5 edges after the stable rise.
        pb_in = 1'b1; tick(1);
        pb_in = 1'b0; tick(1);
        pb_in = 1'b1; tick(1);
        pb_in = 1'b0; tick(1);
        press_expect();
        tick(20);
        pb_in = 1'b0;
        tick(15);
        check("cnt_after_bounce", press_cnt, 8'd2);

        // Three-cycle glitch: rejected.
        pb_in = 1'b1; tick(3);
        pb_in = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check("glitch_lvl", {7'd0, pb_level}, 8'd0);
        end
        check("glitch_cnt", press_cnt, 8'd2);

        // Release bounce while held: level stays high, no new pulse.
        press_expect();
        tick(10);
        pb_in = 1'b0; tick(2);
        pb_in = 1'b1;
        for (int i = 0; i < 12; i++) begin
            check("rel_bounce_lvl", {7'd0, pb_level}, 8'd1);
            tick(1);
        end
        pb_in = 1'b0;
        tick(15);
        check("cnt_after_rel_bounce", press_cnt, 8'd3);
        check("lvl_after_rel_bounce", {7'd0, pb_level}, 8'd0);

        // Asynchronous reset in PCHK with cnt=2: outputs clear, no later pulse.
        pb_in = 1'b1;
        tick(4);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_t_pulse", {7'd0, t_pulse}, 8'd0);
        check("midrst_pb_level", {7'd0, pb_level}, 8'd0);
        check("midrst_press_cnt", press_cnt, 8'd0);
        @(negedge clk);
        pb_in   = 1'b0;
        exp_cnt = 8'd0;
        tick(2);
        rst_n = 1'b1;
        tick(20);
        check("midrst_cnt_after", press_cnt, 8'd0);
        check("midrst_lvl_after", {7'd0, pb_level}, 8'd0);

        // 256 clean press/release pairs: counter wraps to 0, toggle FF back to 0.
        for (int i = 0; i < 256; i++) begin
            press_expect();
            tick(8);
            pb_in = 1'b0;
            tick(10);
        end
        check("wrap_press_cnt", press_cnt, 8'd0);
        check("wrap_tff", {7'd0, tff}, 8'd0);

        // pb_in already high when reset releases: debounced as a new press.
        rst_n   = 1'b0;
        pb_in   = 1'b1;
        exp_cnt = 8'd0;
        tick(2);
        rst_n = 1'b1;
        begin
            exp_t e;
            exp_cnt = 8'd1;
            e.cyc   = cyc + 1 + 5;
            e.cnt   = exp_cnt;
            exp_q.push_back(e);
        end
        tick(15);
        pb_in = 1'b0;
        tick(15);
        check("rst_high_cnt", press_cnt, 8'd1);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_pulses got=%0d outstanding required=0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
